// File: rtl/vram_arbiter.sv
// vram_arbiter: single-port text VRAM slot arbiter, scan-line character fetches over buffered host writes
module vram_arbiter #(
    parameter int         C_COLS       = 40,
    parameter int         C_ROWS       = 24,
    parameter int         C_AW         = 10,
    parameter int         C_FIFO_DEPTH = 4,
    parameter logic [2:0] C_FETCH_PH   = 3'd0
) (
    input  logic            CK_i,
    input  logic            RST_i,
    input  logic            CK_EE_i,
    input  logic [9:0]      HCTRs_i,
    input  logic [8:0]      VCTRs_i,
    input  logic            XBLK_i,
    input  logic            WR_i,
    input  logic [C_AW-1:0] WADRs_i,
    input  logic [7:0]      WDATs_i,
    output logic            WRDY_o,
    output logic            OVF_o,
    output logic [C_AW-1:0] RAM_ADRs_o,
    output logic            RAM_WE_o,
    output logic [7:0]      RAM_WDATs_o,
    input  logic [7:0]      RAM_RDATs_i,
    output logic [7:0]      CHRs_o,
    output logic            CHR_VLD_o,
    output logic [2:0]      CELL_LINEs_o
);
    localparam int CW = $clog2(C_COLS + 1);
    localparam int PW = $clog2(C_FIFO_DEPTH);
    localparam int NW = PW + 1;
    localparam int EW = C_AW + 8;

    logic [EW-1:0]   mem_q [C_FIFO_DEPTH];
    logic [PW-1:0]   wp_q, wp_d, rp_q, rp_d;
    logic [NW-1:0]   cnt_q, cnt_d;
    logic [CW-1:0]   col_q, col_d;
    logic [C_AW-1:0] adr_q, adr_d, fa;
    logic [7:0]      wdat_q, wdat_d, chr_q, chr_d;
    logic [2:0]      ln_q, ln_d, cell_q, cell_d;
    logic            we_q, we_d, fp_q, fp_d, vld_q, vld_d, wrdy_q, wrdy_d, ovf_q, ovf_d;
    logic [5:0]      row;
    logic [EW-1:0]   head;
    logic            full, fetch, push, pop, unused_hctr;

    assign row         = VCTRs_i[8:3];
    assign unused_hctr = ^HCTRs_i[9:3];
    assign full        = cnt_q == NW'(C_FIFO_DEPTH);
    assign fetch       = CK_EE_i && XBLK_i && HCTRs_i[2:0] == C_FETCH_PH &&
                         int'(row) < C_ROWS && int'(col_q) < C_COLS;
    assign push        = CK_EE_i && WR_i && !full;
    assign pop         = CK_EE_i && !fetch && cnt_q != '0;
    assign fa          = C_AW'(16'(row) * 16'(C_COLS) + 16'(col_q));
    assign head        = mem_q[rp_q];

    // Slot decision: fetch wins, otherwise drain one FIFO entry; read data returns one enabled cycle after a fetch
    always_comb begin
        col_d  = col_q;
        cnt_d  = cnt_q;
        wp_d   = wp_q;
        rp_d   = rp_q;
        adr_d  = adr_q;
        we_d   = we_q;
        wdat_d = wdat_q;
        fp_d   = fp_q;
        ln_d   = ln_q;
        chr_d  = chr_q;
        vld_d  = vld_q;
        cell_d = cell_q;
        ovf_d  = ovf_q;
        if (CK_EE_i) begin
            col_d  = !XBLK_i ? '0 : fetch ? col_q + CW'(1) : col_q;
            cnt_d  = cnt_q + NW'(push) - NW'(pop);
            wp_d   = wp_q + PW'(push);
            rp_d   = rp_q + PW'(pop);
            adr_d  = fetch ? fa : pop ? head[EW-1:8] : adr_q;
            we_d   = pop;
            wdat_d = pop ? head[7:0] : wdat_q;
            fp_d   = fetch;
            ln_d   = fetch ? VCTRs_i[2:0] : ln_q;
            chr_d  = fp_q ? RAM_RDATs_i : chr_q;
            vld_d  = fp_q;
            cell_d = fp_q ? ln_q : cell_q;
            ovf_d  = ovf_q | (WR_i & full);
        end
        wrdy_d = cnt_d != NW'(C_FIFO_DEPTH);
    end

    // State registers; reset drops queued writes and any read still in flight
    always_ff @(posedge CK_i) begin
        if (RST_i) begin
            col_q  <= '0;
            cnt_q  <= '0;
            wp_q   <= '0;
            rp_q   <= '0;
            adr_q  <= '0;
            we_q   <= 1'b0;
            wdat_q <= '0;
            fp_q   <= 1'b0;
            ln_q   <= '0;
            chr_q  <= '0;
            vld_q  <= 1'b0;
            cell_q <= '0;
            wrdy_q <= 1'b1;
            ovf_q  <= 1'b0;
        end else begin
            col_q  <= col_d;
            cnt_q  <= cnt_d;
            wp_q   <= wp_d;
            rp_q   <= rp_d;
            adr_q  <= adr_d;
            we_q   <= we_d;
            wdat_q <= wdat_d;
            fp_q   <= fp_d;
            ln_q   <= ln_d;
            chr_q  <= chr_d;
            vld_q  <= vld_d;
            cell_q <= cell_d;
            wrdy_q <= wrdy_d;
            ovf_q  <= ovf_d;
        end
    end

    // FIFO storage; stale entries are made unreachable by the pointer reset
    always_ff @(posedge CK_i) begin
        if (push) mem_q[wp_q] <= {WADRs_i, WDATs_i};
    end

    assign WRDY_o       = wrdy_q;
    assign OVF_o        = ovf_q;
    assign RAM_ADRs_o   = adr_q;
    assign RAM_WE_o     = we_q & CK_EE_i;
    assign RAM_WDATs_o  = wdat_q;
    assign CHRs_o       = chr_q;
    assign CHR_VLD_o    = vld_q & CK_EE_i;
    assign CELL_LINEs_o = cell_q;
endmodule

// File: tb/tb_vram_arbiter.sv
// tb_vram_arbiter: directed self-checking bench for vram_arbiter
module tb_vram_arbiter;
    logic       CK_i = 1'b0;
    logic       RST_i, CK_EE_i, XBLK_i, WR_i;
    logic [9:0] HCTRs_i;
    logic [8:0] VCTRs_i;
    logic [9:0] WADRs_i;
    logic [7:0] WDATs_i;
    logic       WRDY_o, OVF_o, RAM_WE_o, CHR_VLD_o;
    logic [9:0] RAM_ADRs_o;
    logic [7:0] RAM_WDATs_o, RAM_RDATs_i, CHRs_o;
    logic [2:0] CELL_LINEs_o;
    int         n_cmp = 0;
    int         n_err = 0;

    vram_arbiter dut (
        .CK_i(CK_i), .RST_i(RST_i), .CK_EE_i(CK_EE_i), .HCTRs_i(HCTRs_i), .VCTRs_i(VCTRs_i),
        .XBLK_i(XBLK_i), .WR_i(WR_i), .WADRs_i(WADRs_i), .WDATs_i(WDATs_i), .WRDY_o(WRDY_o),
        .OVF_o(OVF_o), .RAM_ADRs_o(RAM_ADRs_o), .RAM_WE_o(RAM_WE_o), .RAM_WDATs_o(RAM_WDATs_o),
        .RAM_RDATs_i(RAM_RDATs_i), .CHRs_o(CHRs_o), .CHR_VLD_o(CHR_VLD_o), .CELL_LINEs_o(CELL_LINEs_o)
    );

    // VRAM content: each location holds its low address byte scrambled
    assign RAM_RDATs_i = RAM_ADRs_o[7:0] ^ 8'hA5;

    always #5 CK_i = ~CK_i;

    function automatic logic [31:0] f_chr(input int a);
        logic [7:0] b;
        b = 8'(a) ^ 8'hA5;
        return 32'(b);
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick;
        @(posedge CK_i);
        #1;
    endtask

    task automatic drv_en(input int j);
        CK_EE_i = (j % 2 == 0);
        HCTRs_i = 10'(j / 2);
        WR_i    = (j == 2 || j == 3);
        WADRs_i = (j == 2) ? 10'd300 : 10'd301;
        WDATs_i = (j == 2) ? 8'h33 : 8'h34;
    endtask

    initial begin
        int nv, nw;
        int ea[3];
        logic [7:0] ed[3];
        RST_i = 1'b1; CK_EE_i = 1'b1; XBLK_i = 1'b0; WR_i = 1'b0;
        HCTRs_i = '0; VCTRs_i = '0; WADRs_i = '0; WDATs_i = '0;

        // reset
        for (int i = 0; i < 3; i++) begin
            tick;
            check("rst_wrdy", 32'(WRDY_o), 1);
            check("rst_ovf", 32'(OVF_o), 0);
            check("rst_we", 32'(RAM_WE_o), 0);
            check("rst_vld", 32'(CHR_VLD_o), 0);
        end
        check("rst_adr", 32'(RAM_ADRs_o), 0);
        check("rst_wdat", 32'(RAM_WDATs_o), 0);
        check("rst_chr", 32'(CHRs_o), 0);
        check("rst_cell", 32'(CELL_LINEs_o), 0);
        RST_i = 1'b0;
        tick;

        // full active line, row 1 line 1
        nv = 0; nw = 0;
        for (int h = 0; h < 400; h++) begin
            XBLK_i = 1'b1; VCTRs_i = 9'd9; HCTRs_i = 10'(h);
            tick;
            if (h % 8 == 0 && h < 320) check("line_adr", 32'(RAM_ADRs_o), 32'(40 + h / 8));
            check("line_vld", 32'(CHR_VLD_o), 32'(h % 8 == 1 && h < 321));
            if (CHR_VLD_o) begin
                nv++;
                check("line_chr", 32'(CHRs_o), f_chr(40 + (h - 1) / 8));
                check("line_cell", 32'(CELL_LINEs_o), 1);
            end
            if (RAM_WE_o) nw++;
        end
        check("line_nfetch", 32'(nv), 40);
        check("line_nwe", 32'(nw), 0);

        // fill the FIFO under back-to-back fetch slots, then drain in blanking
        XBLK_i = 1'b0; WR_i = 1'b0;
        tick;
        for (int k = 0; k < 4; k++) begin
            XBLK_i = 1'b1; VCTRs_i = 9'd0; HCTRs_i = 10'd0;
            WR_i = 1'b1; WADRs_i = 10'(5 + k); WDATs_i = 8'(8'h41 + k);
            tick;
            check("coll_adr", 32'(RAM_ADRs_o), 32'(k));
            check("coll_we", 32'(RAM_WE_o), 0);
            check("fill_wrdy", 32'(WRDY_o), 32'(k < 3));
            check("fill_vld", 32'(CHR_VLD_o), 32'(k > 0));
        end
        XBLK_i = 1'b0; WR_i = 1'b0;
        for (int k = 0; k < 4; k++) begin
            tick;
            check("blk_we", 32'(RAM_WE_o), 1);
            check("blk_adr", 32'(RAM_ADRs_o), 32'(5 + k));
            check("blk_wdat", 32'(RAM_WDATs_o), 32'(8'h41 + k));
            check("blk_wrdy", 32'(WRDY_o), 1);
            check("blk_vld", 32'(CHR_VLD_o), 32'(k == 0));
            if (k == 0) check("blk_chr", 32'(CHRs_o), f_chr(3));
        end
        tick;
        check("blk_idle_we", 32'(RAM_WE_o), 0);
        check("blk_idle_adr", 32'(RAM_ADRs_o), 8);

        // overflow: fill, full fetch slot, then dropped push while full
        tick;
        XBLK_i = 1'b1; VCTRs_i = 9'd8;
        for (int k = 0; k < 4; k++) begin
            HCTRs_i = 10'd0; WR_i = 1'b1; WADRs_i = 10'(100 + k); WDATs_i = 8'(8'h60 + k);
            tick;
            check("ovf_fadr", 32'(RAM_ADRs_o), 32'(40 + k));
            check("ovf_ovf0", 32'(OVF_o), 0);
        end
        check("ovf_full", 32'(WRDY_o), 0);
        HCTRs_i = 10'd0; WR_i = 1'b0;
        tick;
        check("full_fetch_adr", 32'(RAM_ADRs_o), 44);
        check("full_fetch_we", 32'(RAM_WE_o), 0);
        check("full_fetch_wrdy", 32'(WRDY_o), 0);
        HCTRs_i = 10'd1; WR_i = 1'b1; WADRs_i = 10'd104; WDATs_i = 8'h64;
        tick;
        check("drop_we", 32'(RAM_WE_o), 1);
        check("drop_adr", 32'(RAM_ADRs_o), 100);
        check("drop_wdat", 32'(RAM_WDATs_o), 32'h60);
        check("drop_ovf", 32'(OVF_o), 1);
        check("drop_wrdy", 32'(WRDY_o), 1);
        check("drop_vld", 32'(CHR_VLD_o), 1);
        check("drop_chr", 32'(CHRs_o), f_chr(44));
        HCTRs_i = 10'd2; WADRs_i = 10'd105; WDATs_i = 8'h65;
        tick;
        check("p5_adr", 32'(RAM_ADRs_o), 101);
        check("p5_wdat", 32'(RAM_WDATs_o), 32'h61);
        WR_i = 1'b0;
        ea = '{102, 103, 105};
        ed = '{8'h62, 8'h63, 8'h65};
        for (int k = 0; k < 3; k++) begin
            HCTRs_i = 10'(3 + k);
            tick;
            check("drain_we", 32'(RAM_WE_o), 1);
            check("drain_adr", 32'(RAM_ADRs_o), 32'(ea[k]));
            check("drain_wdat", 32'(RAM_WDATs_o), 32'(ed[k]));
        end
        HCTRs_i = 10'd6;
        tick;
        check("drain_idle_we", 32'(RAM_WE_o), 0);
        check("ovf_sticky", 32'(OVF_o), 1);

        // collision: write queued just before a fetch slot waits one cycle
        HCTRs_i = 10'd7; WR_i = 1'b1; WADRs_i = 10'd200; WDATs_i = 8'h77;
        tick;
        check("c_push_we", 32'(RAM_WE_o), 0);
        HCTRs_i = 10'd0; WR_i = 1'b0;
        tick;
        check("c_fetch_we", 32'(RAM_WE_o), 0);
        check("c_fetch_adr", 32'(RAM_ADRs_o), 45);
        HCTRs_i = 10'd1;
        tick;
        check("c_wr_we", 32'(RAM_WE_o), 1);
        check("c_wr_adr", 32'(RAM_ADRs_o), 200);
        check("c_wr_wdat", 32'(RAM_WDATs_o), 32'h77);

        // clock enable toggling over a full line, row 2 line 1
        XBLK_i = 1'b0;
        tick;
        XBLK_i = 1'b1; VCTRs_i = 9'd17;
        nv = 0; nw = 0;
        for (int j = 0; j < 800; j++) begin
            drv_en(j);
            tick;
            drv_en(j + 1);
            #1;
            if (j % 16 == 0 && j < 640) check("ce_adr", 32'(RAM_ADRs_o), 32'(80 + j / 16));
            if (!CK_EE_i) begin
                check("ce_we_off", 32'(RAM_WE_o), 0);
                check("ce_vld_off", 32'(CHR_VLD_o), 0);
            end
            if (CHR_VLD_o) begin
                nv++;
                check("ce_vld_at", 32'(j % 16), 3);
                check("ce_chr", 32'(CHRs_o), f_chr(80 + (j - 3) / 16));
                check("ce_cell", 32'(CELL_LINEs_o), 1);
            end
            if (RAM_WE_o) begin
                nw++;
                check("ce_we_at", 32'(j), 5);
                check("ce_wadr", 32'(RAM_ADRs_o), 300);
                check("ce_wdat", 32'(RAM_WDATs_o), 32'h33);
            end
        end
        check("ce_nfetch", 32'(nv), 40);
        check("ce_nwe", 32'(nw), 1);
        CK_EE_i = 1'b1; WR_i = 1'b0;

        // reset with three queued writes and a fetch in flight; reset beats a low enable
        XBLK_i = 1'b0;
        tick;
        for (int k = 0; k < 3; k++) begin
            XBLK_i = 1'b1; VCTRs_i = 9'd0; HCTRs_i = 10'd0;
            WR_i = 1'b1; WADRs_i = 10'(400 + k); WDATs_i = 8'(k);
            tick;
        end
        RST_i = 1'b1; CK_EE_i = 1'b0; WR_i = 1'b0; XBLK_i = 1'b0;
        tick;
        RST_i = 1'b0; CK_EE_i = 1'b1;
        #1;
        check("mrst_wrdy", 32'(WRDY_o), 1);
        check("mrst_ovf", 32'(OVF_o), 0);
        check("mrst_we", 32'(RAM_WE_o), 0);
        check("mrst_vld", 32'(CHR_VLD_o), 0);
        for (int k = 0; k < 4; k++) begin
            tick;
            check("post_rst_we", 32'(RAM_WE_o), 0);
            check("post_rst_vld", 32'(CHR_VLD_o), 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
